// File: rtl/peri_bus_arbiter.sv
// peri_bus_arbiter: round-robin arbiter sharing one single-master peripheral
// bus between NUM_REQ requesters. One transaction in flight at a time:
// grant -> one-cycle downstream strobe -> wait for ready (bounded by TIMEOUT)
// -> one-cycle ready/err/rdata back to the winner.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_rden/wren       per-requester read/write request (held until ready)
//   i_req_addr/wdata      per-requester address / write data (32b lanes)
//   i_req_wstrb           per-requester byte strobes (4b lanes)
//   o_req_gnt             one-hot pulse: request latched
//   o_req_ready           one-hot pulse: transaction complete
//   o_req_err             qualifies o_req_ready: transaction timed out
//   o_req_rdata           read data, valid with o_req_ready
//   o_peri_*              downstream strobes, address, write data, strobes
//   i_peri_ready/rdata    downstream completion and read data
//   o_busy                high whenever the FSM is not idle
module peri_bus_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_rden,
    input  logic [NUM_REQ-1:0]      i_req_wren,
    input  logic [NUM_REQ*32-1:0]   i_req_addr,
    input  logic [NUM_REQ*32-1:0]   i_req_wdata,
    input  logic [NUM_REQ*4-1:0]    i_req_wstrb,
    output logic [NUM_REQ-1:0]      o_req_gnt,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [NUM_REQ-1:0]      o_req_err,
    output logic [31:0]             o_req_rdata,
    output logic                    o_peri_rden,
    output logic                    o_peri_wren,
    output logic [31:0]             o_peri_addr,
    output logic [31:0]             o_peri_wdata,
    output logic [3:0]              o_peri_wstrb,
    input  logic                    i_peri_ready,
    input  logic [31:0]             i_peri_rdata,
    output logic                    o_busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    // ptr doubles as the latched winner index: both are set to the same value on grant.
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   peri_rden_q, peri_rden_d;
    logic                   peri_wren_q, peri_wren_d;
    logic [NUM_REQ-1:0]     req_gnt_q, req_gnt_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]     req_err_q, req_err_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     pending_c;
    logic                   pick_vld_c;
    logic [IDX_W-1:0]       pick_idx_c;
    logic [31:0]            sel_addr_c;
    logic [31:0]            sel_wdata_c;
    logic [3:0]             sel_wstrb_c;
    logic [CNT_W-1:0]       cnt_inc_c;

    assign pending_c = i_req_rden | i_req_wren;
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Round-robin pick: first pending above ptr, then wrap to indices at or below ptr.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld_c && pending_c[j] && (j > 32'(ptr_q))) begin
                pick_vld_c = 1'b1;
                pick_idx_c = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld_c && pending_c[j] && (j <= 32'(ptr_q))) begin
                pick_vld_c = 1'b1;
                pick_idx_c = IDX_W'(j);
            end
        end
    end

    // Payload mux for the picked requester.
    always_comb begin
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_wstrb_c = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == pick_idx_c) begin
                sel_addr_c  = i_req_addr[j*32 +: 32];
                sel_wdata_c = i_req_wdata[j*32 +: 32];
                sel_wstrb_c = i_req_wstrb[j*4 +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = i_peri_ready ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (i_peri_ready || (cnt_q == CNT_MAX)) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; pulses default low, latched fields hold.
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        peri_rden_d = 1'b0;
        peri_wren_d = 1'b0;
        req_gnt_d   = '0;
        req_ready_d = '0;
        req_err_d   = '0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_c) begin
                    ptr_d                 = pick_idx_c;
                    addr_d                = sel_addr_c;
                    wdata_d               = sel_wdata_c;
                    wstrb_d               = sel_wstrb_c;
                    // Write takes precedence when both rden and wren are set.
                    peri_wren_d           = i_req_wren[pick_idx_c];
                    peri_rden_d           = ~i_req_wren[pick_idx_c];
                    req_gnt_d[pick_idx_c] = 1'b1;
                    cnt_d                 = CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (i_peri_ready) begin
                    rdata_d            = i_peri_rdata;
                    req_ready_d[ptr_q] = 1'b1;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ST_WAIT: begin
                // Ready beats a coincident timeout.
                if (i_peri_ready) begin
                    rdata_d            = i_peri_rdata;
                    req_ready_d[ptr_q] = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d            = '0;
                    req_ready_d[ptr_q] = 1'b1;
                    req_err_d[ptr_q]   = 1'b1;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            peri_rden_q <= 1'b0;
            peri_wren_q <= 1'b0;
            req_gnt_q   <= '0;
            req_ready_q <= '0;
            req_err_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            peri_rden_q <= peri_rden_d;
            peri_wren_q <= peri_wren_d;
            req_gnt_q   <= req_gnt_d;
            req_ready_q <= req_ready_d;
            req_err_q   <= req_err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_req_gnt    = req_gnt_q;
    assign o_req_ready  = req_ready_q;
    assign o_req_err    = req_err_q;
    assign o_req_rdata  = rdata_q;
    assign o_peri_rden  = peri_rden_q;
    assign o_peri_wren  = peri_wren_q;
    assign o_peri_addr  = addr_q;
    assign o_peri_wdata = wdata_q;
    assign o_peri_wstrb = wstrb_q;
    assign o_busy       = busy_q;

endmodule
